pixel_frame_buffer: RTL and testbench

- Sits directly downstream of the top-level PMOD pixel receiver FSM, which accepts 8-bit pixels from the external sender using a valid/ack handshake.
- Collects a 28x28 greyscale image (784 bytes) into one of two ping-pong banks.
- Presents each completed frame to the CPU-side peripheral through a synchronous read port and frame-ready/release flags.
- Back-pressures the receiver when both banks hold unconsumed frames.

---
 rtl/pixbuf_pkg.sv | 14 +
 rtl/pixbuf_bank_ram.sv | 41 ++++
 rtl/pixel_frame_buffer.sv | 89 ++++++++
 tb/tb_pixel_frame_buffer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pixbuf_pkg.sv
// Shared sizing and types for the ping-pong pixel frame buffer.
package pixbuf_pkg;

   localparam int PIXELS = 784;
   localparam int DATA_W = 8;
   localparam int IDX_W  = 10;

   typedef logic [DATA_W-1:0] pix_t;
   typedef logic [IDX_W-1:0]  idx_t;

   // Highest valid pixel index; also the fill terminal count.
   localparam idx_t LAST_IDX = idx_t'(PIXELS - 1);

endpackage

// File: rtl/pixbuf_bank_ram.sv
// Two-bank pixel store: one write port, one registered read port.
// Address is {bank, idx}; the array is left unreset so it maps onto block RAM.
module pixbuf_bank_ram
   import pixbuf_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_en,
   input  logic              wr_bank,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_bank,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 2 * (2 ** IDX_W);

   pix_t mem [DEPTH];
   logic rd_in_range;

   assign rd_in_range = (rd_idx <= LAST_IDX);

   // Pixel write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{wr_bank, wr_idx}] <= wr_data;
      end
   end

   // Registered read; indices past the frame read as zero, output holds when idle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= rd_in_range ? mem[{rd_bank, rd_idx}] : '0;
      end
   end

endmodule

// File: rtl/pixel_frame_buffer.sv
// Collects 28x28 greyscale frames into alternating banks and presents
// completed frames to the CPU side. Receiver is stalled while both banks
// hold unreleased frames.
module pixel_frame_buffer
   import pixbuf_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_pix_valid,
   output logic              o_pix_ready,
   input  logic [DATA_W-1:0] i_pix_data,
   input  logic              i_frame_sync,
   input  logic [IDX_W-1:0]  i_rd_addr,
   input  logic              i_rd_en,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_frame_ready,
   input  logic              i_frame_release,
   output logic [7:0]        o_drop_cnt,
   output logic [15:0]       o_frames_done
);

   logic       wr_bank;
   logic       rd_bank;
   logic [1:0] full;
   idx_t       wr_idx;

   logic       accept;
   logic       wr_last;
   logic       release_ok;
   idx_t       wr_idx_eff;

   assign o_pix_ready   = ~full[wr_bank];
   assign o_frame_ready = full[rd_bank];

   assign accept     = i_pix_valid & o_pix_ready;
   // A sync redirects the coincident pixel to index 0, so it can never complete a frame.
   assign wr_last    = accept & ~i_frame_sync & (wr_idx == LAST_IDX);
   assign release_ok = i_frame_release & o_frame_ready;
   assign wr_idx_eff = i_frame_sync ? '0 : wr_idx;

   // Fill index, bank pointers, full flags and frame counters.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_bank       <= 1'b0;
         rd_bank       <= 1'b0;
         full          <= '0;
         wr_idx        <= '0;
         o_drop_cnt    <= '0;
         o_frames_done <= '0;
      end else begin
         if (i_frame_sync) begin
            wr_idx <= accept ? idx_t'(1) : '0;
         end else if (accept) begin
            wr_idx <= wr_last ? '0 : wr_idx + 1'b1;
         end

         if (i_frame_sync && (wr_idx != '0) && (o_drop_cnt != 8'hFF)) begin
            o_drop_cnt <= o_drop_cnt + 1'b1;
         end

         // Completion needs full[wr_bank]=0 and release needs full[rd_bank]=1,
         // so the two updates below always touch different banks.
         if (wr_last) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
            o_frames_done <= o_frames_done + 1'b1;
         end

         if (release_ok) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
      end
   end

   pixbuf_bank_ram u_ram (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (accept),
      .wr_bank (wr_bank),
      .wr_idx  (wr_idx_eff),
      .wr_data (i_pix_data),
      .rd_en   (i_rd_en),
      .rd_bank (rd_bank),
      .rd_idx  (i_rd_addr),
      .rd_data (o_rd_data)
   );

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Self-checking bench for pixel_frame_buffer: directed sequences, a read
// vector table, and a randomized run against a frame-queue reference model.
module tb_pixel_frame_buffer;

   localparam int NPIX = 784;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        i_pix_valid = 1'b0;
   logic        o_pix_ready;
   logic [7:0]  i_pix_data = '0;
   logic        i_frame_sync = 1'b0;
   logic [9:0]  i_rd_addr = '0;
   logic        i_rd_en = 1'b0;
   logic [7:0]  o_rd_data;
   logic        o_frame_ready;
   logic        i_frame_release = 1'b0;
   logic [7:0]  o_drop_cnt;
   logic [15:0] o_frames_done;

   pixel_frame_buffer dut (
      .clk             (clk),
      .rstn            (rstn),
      .i_pix_valid     (i_pix_valid),
      .o_pix_ready     (o_pix_ready),
      .i_pix_data      (i_pix_data),
      .i_frame_sync    (i_frame_sync),
      .i_rd_addr       (i_rd_addr),
      .i_rd_en         (i_rd_en),
      .o_rd_data       (o_rd_data),
      .o_frame_ready   (o_frame_ready),
      .i_frame_release (i_frame_release),
      .o_drop_cnt      (o_drop_cnt),
      .o_frames_done   (o_frames_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: up to two completed frames in FIFO order plus the
   // frame currently being collected.
   logic [7:0] fq [2][NPIX];
   logic [7:0] pbuf [NPIX];
   int         m_head, m_count, m_widx, m_drop, m_done;
   logic [7:0] m_rd;
   bit         m_rd_known;

   typedef struct {
      int addr;
      int exp;
   } rd_vec_t;
   rd_vec_t tbl [7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_head = 0; m_count = 0; m_widx = 0; m_drop = 0; m_done = 0;
      m_rd = '0; m_rd_known = 1'b1;
   endtask

   task automatic model_step(input bit v, input logic [7:0] d, input bit sync,
                             input bit rd, input int addr, input bit rel);
      bit acc;
      bit relok;
      acc   = v && (m_count < 2);
      relok = rel && (m_count > 0);
      if (rd) begin
         if (addr >= NPIX) begin
            m_rd = '0; m_rd_known = 1'b1;
         end else if (m_count > 0) begin
            m_rd = fq[m_head][addr]; m_rd_known = 1'b1;
         end else begin
            m_rd_known = 1'b0;
         end
      end
      if (sync) begin
         if (m_widx != 0 && m_drop < 255) m_drop++;
         m_widx = 0;
      end
      if (acc) begin
         pbuf[m_widx] = d;
         m_widx++;
         if (m_widx == NPIX) begin
            for (int i = 0; i < NPIX; i++) fq[(m_head + m_count) % 2][i] = pbuf[i];
            m_count++;
            m_widx = 0;
            m_done = (m_done + 1) % 65536;
         end
      end
      if (relok) begin
         m_head = (m_head + 1) % 2;
         m_count--;
      end
   endtask

   task automatic check_model();
      chk("pix_ready", int'(o_pix_ready), int'(m_count < 2));
      chk("frame_ready", int'(o_frame_ready), int'(m_count > 0));
      chk("drop_cnt", int'(o_drop_cnt), m_drop);
      chk("frames_done", int'(o_frames_done), m_done);
      if (m_rd_known) chk("rd_data", int'(o_rd_data), int'(m_rd));
   endtask

   // One clock: drive, step the model at the edge, sample 1 time unit later.
   task automatic cyc(input bit v, input logic [7:0] d, input bit sync,
                      input bit rd, input int addr, input bit rel);
      i_pix_valid = v; i_pix_data = d; i_frame_sync = sync;
      i_rd_en = rd; i_rd_addr = addr[9:0]; i_frame_release = rel;
      @(posedge clk);
      model_step(v, d, sync, rd, addr, rel);
      #1;
      i_pix_valid = 1'b0; i_frame_sync = 1'b0; i_rd_en = 1'b0; i_frame_release = 1'b0;
      check_model();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      i_pix_valid = 1'b0; i_frame_sync = 1'b0; i_rd_en = 1'b0; i_frame_release = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      rstn = 1'b1;
      check_model();
   endtask

   task automatic send(input int n, input int base);
      for (int i = 0; i < n; i++) cyc(1'b1, 8'((i + base) % 256), 1'b0, 1'b0, 0, 1'b0);
   endtask

   task automatic rd_chk(input string name, input int addr, input int exp);
      cyc(1'b0, '0, 1'b0, 1'b1, addr, 1'b0);
      chk(name, int'(o_rd_data), exp);
   endtask

   initial begin
      tbl[0] = '{addr: 5,    exp: 5};
      tbl[1] = '{addr: 300,  exp: 44};
      tbl[2] = '{addr: 783,  exp: 15};
      tbl[3] = '{addr: 800,  exp: 0};
      tbl[4] = '{addr: 0,    exp: 0};
      tbl[5] = '{addr: 255,  exp: 255};
      tbl[6] = '{addr: 1023, exp: 0};

      do_reset();
      chk("rst_pix_ready", int'(o_pix_ready), 1);
      chk("rst_frame_ready", int'(o_frame_ready), 0);
      chk("rst_drop", int'(o_drop_cnt), 0);
      chk("rst_done", int'(o_frames_done), 0);
      chk("rst_rd_data", int'(o_rd_data), 0);

      // Release with nothing presented is ignored.
      cyc(1'b0, '0, 1'b0, 1'b0, 0, 1'b1);
      chk("idle_rel_pix_ready", int'(o_pix_ready), 1);
      chk("idle_rel_frame_ready", int'(o_frame_ready), 0);

      // Frame 1: value = index mod 256.
      send(NPIX - 1, 0);
      chk("f1_not_ready_early", int'(o_frame_ready), 0);
      cyc(1'b1, 8'((NPIX - 1) % 256), 1'b0, 1'b0, 0, 1'b0);
      chk("f1_ready", int'(o_frame_ready), 1);
      chk("f1_done", int'(o_frames_done), 1);
      for (int k = 0; k < 7; k++) rd_chk("tbl_rd", tbl[k].addr, tbl[k].exp);
      rd_chk("rd_300", 300, 44);
      cyc(1'b0, '0, 1'b0, 1'b0, 0, 1'b0);
      chk("rd_hold", int'(o_rd_data), 44);

      // Frame 2 with no release: both banks full.
      send(NPIX, 7);
      chk("dbl_pix_ready", int'(o_pix_ready), 0);
      chk("dbl_done", int'(o_frames_done), 2);
      send(10, 8'hE0);
      chk("dbl_stall_done", int'(o_frames_done), 2);
      chk("dbl_stall_ready", int'(o_pix_ready), 0);
      cyc(1'b0, '0, 1'b0, 1'b0, 0, 1'b1);
      chk("rel_pix_ready", int'(o_pix_ready), 1);
      chk("rel_frame_ready", int'(o_frame_ready), 1);
      rd_chk("f2_rd3", 3, 10);
      rd_chk("f2_rd0", 0, 7);

      // Completion and release in the same cycle.
      send(NPIX - 1, 8'h20);
      cyc(1'b1, 8'((NPIX - 1 + 8'h20) % 256), 1'b0, 1'b0, 0, 1'b1);
      chk("cr_done", int'(o_frames_done), 3);
      chk("cr_frame_ready", int'(o_frame_ready), 1);
      chk("cr_pix_ready", int'(o_pix_ready), 1);
      rd_chk("cr_rd0", 0, 8'h20);
      cyc(1'b0, '0, 1'b0, 1'b0, 0, 1'b1);
      chk("cr_empty", int'(o_frame_ready), 0);

      // Sync mid-frame discards the partial frame.
      send(100, 0);
      cyc(1'b0, '0, 1'b1, 1'b0, 0, 1'b0);
      chk("sync_drop", int'(o_drop_cnt), 1);
      for (int i = 0; i < NPIX; i++) cyc(1'b1, 8'hA5, 1'b0, 1'b0, 0, 1'b0);
      chk("sync_done", int'(o_frames_done), 4);
      for (int a = 0; a < NPIX; a += 13) rd_chk("sync_rd_a5", a, 8'hA5);
      rd_chk("sync_rd_last", NPIX - 1, 8'hA5);
      cyc(1'b0, '0, 1'b0, 1'b0, 0, 1'b1);

      // Sync coincident with an accept at index 0.
      cyc(1'b1, 8'h3C, 1'b1, 1'b0, 0, 1'b0);
      chk("sync0_drop", int'(o_drop_cnt), 1);
      for (int i = 0; i < NPIX - 1; i++) cyc(1'b1, 8'h11, 1'b0, 1'b0, 0, 1'b0);
      chk("sync0_done", int'(o_frames_done), 5);
      rd_chk("sync0_rd0", 0, 8'h3C);
      rd_chk("sync0_rd1", 1, 8'h11);
      cyc(1'b0, '0, 1'b0, 1'b0, 0, 1'b1);

      // Reset mid-fill, then a full frame.
      send(400, 0);
      do_reset();
      send(NPIX, 8'h40);
      chk("rstfill_drop", int'(o_drop_cnt), 0);
      chk("rstfill_done", int'(o_frames_done), 1);
      chk("rstfill_frame_ready", int'(o_frame_ready), 1);
      chk("rstfill_pix_ready", int'(o_pix_ready), 1);
      rd_chk("rstfill_rd0", 0, 8'h40);
      cyc(1'b0, '0, 1'b0, 1'b0, 0, 1'b1);
      chk("rstfill_one_frame", int'(o_frame_ready), 0);

      // Randomized traffic against the model.
      for (int n = 0; n < 5000; n++) begin
         cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 2000) == 0,
             ($urandom % 2) == 0, int'($urandom_range(0, 1023)), ($urandom % 500) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
